// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_ctrl_pkg;

  localparam int UART_QBITS_PER_BIT = 4;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    ARM      = 3'd1,
    WAIT     = 3'd2,
    CAPTURE  = 3'd3,
    CLEAR    = 3'd4
  } rx_ctrl_state_t;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead circular FIFO with separate occupancy count; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [LW-1:0]    o_level,
  output logic             o_pop_ok
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign o_empty  = (count_q == LW'(0));
  assign o_full   = (count_q == LW'(DEPTH));
  assign o_level  = count_q;
  assign o_rdata  = mem_q[rptr_q];
  assign do_pop   = i_pop && !o_empty;
  assign do_push  = i_push && (!o_full || do_pop);
  assign o_pop_ok = do_pop;

  // Next storage, pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = i_wdata;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencing controller for uart_rx: quarter-bit tick, re-arm clear,
// byte capture FIFO and sticky overrun. Optional idle timeout: UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
`ifdef UART_RX_CTRL_TIMEOUT_EN
  ,parameter int TMO_TICKS = 10 * UART_QBITS_PER_BIT
`endif
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [DIV_W-1:0]         i_baud_div,
  output logic                     o_rxclken,
  output logic                     o_rxclear,
  input  logic [7:0]               i_rxdata,
  input  logic                     i_rxerr,
  input  logic                     i_rxdone,
  output logic [7:0]               o_data,
  output logic                     o_ferr,
  output logic                     o_valid,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overrun,
  input  logic                     i_err_clear
`ifdef UART_RX_CTRL_TIMEOUT_EN
  ,output logic                    o_timeout
`endif
);

  rx_ctrl_state_t   state_q, state_d;
  logic             rxclear_q, rxclear_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clken_q, clken_d;
  logic             load_q, load_d;
  logic             overrun_q, overrun_d;
  logic             push;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop_ok;
  rx_entry_t        wr_entry;
  rx_entry_t        head;

  assign o_rxclken = clken_q;
  assign o_rxclear = rxclear_q;
  assign o_overrun = overrun_q;
  assign o_valid   = !fifo_empty;
  assign o_data    = head.data;
  assign o_ferr    = head.ferr;
  assign push      = (state_q == CAPTURE) && i_enable;
  assign wr_entry  = '{ferr: i_rxerr, data: i_rxdata};

  // Tick down-counter; load_q makes the first post-reset cycle a reload from i_baud_div.
  always_comb begin
    load_d = 1'b0;
    if (load_q || !i_enable) begin
      cnt_d   = i_baud_div;
      clken_d = 1'b0;
    end else if (cnt_q == {DIV_W{1'b0}}) begin
      cnt_d   = i_baud_div;
      clken_d = 1'b1;
    end else begin
      cnt_d   = cnt_q - DIV_W'(1);
      clken_d = 1'b0;
    end
  end

  // Sequencer next state; clear is derived from the next state so it is aligned with it.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = ARM;
        ARM:      state_d = WAIT;
        WAIT:     state_d = i_rxdone ? CAPTURE : WAIT;
        CAPTURE:  state_d = CLEAR;
        CLEAR:    state_d = WAIT;
        default:  state_d = DISABLED;
      endcase
    end
    case (state_d)
      WAIT:    rxclear_d = 1'b0;
      CAPTURE: rxclear_d = 1'b0;
      default: rxclear_d = 1'b1;
    endcase
  end

  // Sticky overrun: a dropped byte beats a simultaneous clear.
  always_comb begin
    if (push && fifo_full && !fifo_pop_ok) begin
      overrun_d = 1'b1;
    end else if (i_err_clear) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Control registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= DISABLED;
      rxclear_q <= 1'b1;
      cnt_q     <= {DIV_W{1'b0}};
      clken_q   <= 1'b0;
      load_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rxclear_q <= rxclear_d;
      cnt_q     <= cnt_d;
      clken_q   <= clken_d;
      load_q    <= load_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rx_entry_t))
  ) u_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_push   (push),
    .i_wdata  (wr_entry),
    .i_pop    (i_pop),
    .o_rdata  (head),
    .o_empty  (fifo_empty),
    .o_full   (fifo_full),
    .o_level  (o_level),
    .o_pop_ok (fifo_pop_ok)
  );

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TMO_TICKS + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign o_timeout = (tmo_q == TW'(TMO_TICKS));

  // Idle timeout counter saturates at TMO_TICKS until FIFO activity.
  always_comb begin
    if (push || fifo_pop_ok || fifo_empty) begin
      tmo_d = '0;
    end else if (clken_q && (tmo_q != TW'(TMO_TICKS))) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule
